// File: rtl/elevator_scheduler_if.sv
// Request bus between the keypad front end and the elevator scheduler.
interface elevator_scheduler_if #(
  parameter int unsigned FLOOR_W = 3
);
  logic               auth;
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_err;

  modport master (output auth, output req_valid, output req_floor, input req_err);
  modport slave  (input auth, input req_valid, input req_floor, output req_err);
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator scheduler: pending-request bitmap, car motion and door timing.
module elevator_scheduler #(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned FLOOR_W     = 3,
  parameter int unsigned MOVE_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  elevator_scheduler_if.slave   req_if,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic [FLOOR_W-1:0]    current_floor_o,
  output logic                  move_up_o,
  output logic                  move_down_o,
  output logic                  door_open_o,
  output logic                  busy_o
);

  localparam int unsigned CntMax = (DOOR_CYCLES > MOVE_CYCLES) ? DOOR_CYCLES : MOVE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  dir_up_q, dir_up_d;
  logic                  req_err_q, move_up_q, move_down_q, door_open_q, busy_q;

  logic                  accept, reject, door_same;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask, pend_set;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  above, below, ahead_up, ahead_dn, ahead;

  always_comb begin
    accept    = req_if.req_valid && req_if.auth && (32'(req_if.req_floor) < NUM_FLOORS);
    reject    = req_if.req_valid && !accept;
    // A request for the floor whose door is open only extends the door time.
    door_same = accept && (state_q == StDoor) && (req_if.req_floor == floor_q);
    set_mask  = '0;
    if (accept && !door_same) set_mask[req_if.req_floor] = 1'b1;
    pend_set  = pending_q | set_mask;

    next_floor = (state_q == StMoveUp) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    above = 1'b0;
    below = 1'b0;
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q))    above    = 1'b1;
        if (i < int'(floor_q))    below    = 1'b1;
        if (i > int'(next_floor)) ahead_up = 1'b1;
        if (i < int'(next_floor)) ahead_dn = 1'b1;
      end
    end
    ahead = (state_q == StMoveUp) ? ahead_up : ahead_dn;
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    clr_mask = '0;
    unique case (state_q)
      StIdle: begin
        if (pending_q[floor_q]) begin
          state_d           = StDoor;
          clr_mask[floor_q] = 1'b1;
          cnt_d             = CntW'(DOOR_CYCLES - 1);
        end else if (above && (dir_up_q || !below)) begin
          state_d  = StMoveUp;
          dir_up_d = 1'b1;
          cnt_d    = CntW'(MOVE_CYCLES - 1);
        end else if (below) begin
          state_d  = StMoveDown;
          dir_up_d = 1'b0;
          cnt_d    = CntW'(MOVE_CYCLES - 1);
        end
      end
      StMoveUp, StMoveDown: begin
        if (cnt_q == '0) begin
          floor_d = next_floor;
          // Same-cycle request for the arrival floor merges into this stop.
          if (pend_set[next_floor]) begin
            state_d              = StDoor;
            clr_mask[next_floor] = 1'b1;
            cnt_d                = CntW'(DOOR_CYCLES - 1);
          end else if (ahead) begin
            cnt_d = CntW'(MOVE_CYCLES - 1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDoor: begin
        if (door_same)          cnt_d   = CntW'(DOOR_CYCLES - 1);
        else if (cnt_q == '0)   state_d = StIdle;
        else                    cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
    pending_d = pend_set & ~clr_mask;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      floor_q     <= '0;
      cnt_q       <= '0;
      dir_up_q    <= 1'b1;
      req_err_q   <= 1'b0;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      floor_q     <= floor_d;
      cnt_q       <= cnt_d;
      dir_up_q    <= dir_up_d;
      req_err_q   <= reject;
      move_up_q   <= (state_d == StMoveUp);
      move_down_q <= (state_d == StMoveDown);
      door_open_q <= (state_d == StDoor);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign req_if.req_err  = req_err_q;
  assign pending_o       = pending_q;
  assign current_floor_o = floor_q;
  assign move_up_o       = move_up_q;
  assign move_down_o     = move_down_q;
  assign door_open_o     = door_open_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench: randomized and directed stimulus against a time-based behavioural model.
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int MC = 16;
  localparam int DC = 32;
  localparam int MIdle = 0, MUp = 1, MDown = 2, MDoor = 3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  elevator_scheduler_if #(.FLOOR_W(3)) bus ();
  elevator_scheduler_if #(.FLOOR_W(3)) bus6 ();

  logic [7:0] pending;
  logic [2:0] cur_floor;
  logic       mu, md, door, busy;
  logic [5:0] pending6;
  logic [2:0] cur_floor6;
  logic       mu6, md6, door6, busy6;

  elevator_scheduler dut (
    .CLK(CLK), .RST(RST), .req_if(bus), .pending_o(pending), .current_floor_o(cur_floor),
    .move_up_o(mu), .move_down_o(md), .door_open_o(door), .busy_o(busy)
  );

  elevator_scheduler #(.NUM_FLOORS(6)) dut6 (
    .CLK(CLK), .RST(RST), .req_if(bus6), .pending_o(pending6), .current_floor_o(cur_floor6),
    .move_up_o(mu6), .move_down_o(md6), .door_open_o(door6), .busy_o(busy6)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode, floor, direction, pending set, and the absolute edge of the next event.
  int         cyc;
  int         m_mode, m_floor, m_due;
  bit         m_dir, m_err;
  logic [7:0] m_pend;

  task automatic model_reset();
    m_mode = MIdle; m_floor = 0; m_dir = 1'b1; m_err = 1'b0; m_pend = '0; m_due = 0;
  endtask

  task automatic model_edge(input bit v, input bit a, input int f);
    bit acc, same, hi, lo, beyond;
    logic [7:0] old, nxt;
    cyc++;
    acc   = v && a && (f < NF);
    m_err = v && !acc;
    same  = acc && (m_mode == MDoor) && (f == m_floor);
    old   = m_pend;
    nxt   = old;
    if (acc && !same) nxt[f] = 1'b1;
    case (m_mode)
      MIdle: begin
        hi = 0; lo = 0;
        for (int i = 0; i < NF; i++) if (old[i]) begin
          if (i > m_floor) hi = 1;
          if (i < m_floor) lo = 1;
        end
        if (old[m_floor]) begin
          nxt[m_floor] = 1'b0; m_mode = MDoor; m_due = cyc + DC;
        end else if (hi && (m_dir || !lo)) begin
          m_mode = MUp; m_dir = 1'b1; m_due = cyc + MC;
        end else if (lo) begin
          m_mode = MDown; m_dir = 1'b0; m_due = cyc + MC;
        end
      end
      MUp, MDown: if (cyc == m_due) begin
        m_floor += (m_mode == MUp) ? 1 : -1;
        if (nxt[m_floor]) begin
          nxt[m_floor] = 1'b0; m_mode = MDoor; m_due = cyc + DC;
        end else begin
          beyond = 0;
          for (int i = 0; i < NF; i++)
            if (old[i] && ((m_mode == MUp) ? (i > m_floor) : (i < m_floor))) beyond = 1;
          if (beyond) m_due = cyc + MC;
          else        m_mode = MIdle;
        end
      end
      default: begin
        if (same)             m_due = cyc + DC;
        else if (cyc == m_due) m_mode = MIdle;
      end
    endcase
    m_pend = nxt;
  endtask

  function automatic logic [15:0] exp_vec();
    return {m_err, m_pend, 3'(m_floor), m_mode == MUp, m_mode == MDown, m_mode == MDoor,
            m_mode != MIdle};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bus.req_err, pending, cur_floor, mu, md, door, busy};
  endfunction

  task automatic step(input bit v, input bit a, input logic [2:0] f);
    bus.req_valid = v; bus.auth = a; bus.req_floor = f;
    @(posedge CLK);
    model_edge(v, a, int'(f));
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.req_valid = 0; bus.auth = 0; bus.req_floor = 0;
    bus6.req_valid = 0; bus6.auth = 0; bus6.req_floor = 0;
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.req_valid = 0; bus.auth = 0; bus.req_floor = 0;
    bus6.req_valid = 0; bus6.auth = 0; bus6.req_floor = 0;
    model_reset();
    #3;
    checks++;
    if (dut_vec() !== 16'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec(), 16'h0);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    step(0, 1, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single_trip();
    int t_chg[$];
    int door_cnt, t0, n;
    logic [2:0] prev;
    do_reset();
    step(1, 1, 3);
    t0 = cyc; prev = cur_floor; door_cnt = 0; n = 0;
    while ((n == 0 || busy || pending != 0) && n < 300) begin
      step(0, 1, 0);
      n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL trip_cycle%0d got %h exp %h", n, dut_vec(), exp_vec());
      end
      if (cur_floor != prev) t_chg.push_back(cyc);
      prev = cur_floor;
      if (door) door_cnt++;
    end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL trip_timeout got %0d exp <300", n); end
    checks++;
    if (t_chg.size() != 3 || t_chg[0] - t0 != MC + 1 || t_chg[1] - t_chg[0] != MC ||
        t_chg[2] - t_chg[1] != MC) begin
      errors++; $display("FAIL trip_floor_spacing got %p exp 3 steps of %0d", t_chg, MC);
    end
    checks++;
    if (door_cnt != DC) begin
      errors++; $display("FAIL trip_door_cycles got %0d exp %0d", door_cnt, DC);
    end
    checks++;
    if (cur_floor !== 3'd3 || pending !== 8'h0) begin
      errors++; $display("FAIL trip_end got floor %0d pend %h exp 3 00", cur_floor, pending);
    end
  endtask

  task automatic test_auth_reject();
    do_reset();
    step(1, 0, 5);
    checks++;
    if ({bus.req_err, pending, busy} !== {1'b1, 8'h0, 1'b0}) begin
      errors++; $display("FAIL auth_reject got err%b pend %h busy%b exp 1 00 0",
                         bus.req_err, pending, busy);
    end
    step(0, 1, 0);
    checks++;
    if (bus.req_err !== 1'b0) begin
      errors++; $display("FAIL auth_err_pulse got %b exp 0", bus.req_err);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus6.req_valid = 1; bus6.auth = 1; bus6.req_floor = 3'd7;
    step(0, 1, 0);
    bus6.req_valid = 0;
    checks++;
    if ({bus6.req_err, pending6, busy6, cur_floor6} !== {1'b1, 6'h0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL range_reject got err%b pend %h busy%b exp 1 00 0",
                         bus6.req_err, pending6, busy6);
    end
    bus6.req_valid = 1; bus6.req_floor = 3'd5;
    step(0, 1, 0);
    bus6.req_valid = 0;
    checks++;
    if ({bus6.req_err, pending6} !== {1'b0, 6'b100000}) begin
      errors++; $display("FAIL range_top_accept got err%b pend %b exp 0 100000",
                         bus6.req_err, pending6);
    end
  endtask

  task automatic test_scan();
    int stops[$];
    int n;
    bit prev_door;
    do_reset();
    step(1, 1, 6);
    n = 0;
    while (m_floor != 2 && n < 200) begin step(0, 1, 0); n++; end
    step(0, 1, 0); step(0, 1, 0);
    step(1, 1, 4);
    step(0, 1, 0);
    step(1, 1, 0);
    prev_door = 0; n = 0;
    while ((busy || pending != 0) && n < 2000) begin
      step(0, 1, 0);
      n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL scan_cycle%0d got %h exp %h", n, dut_vec(), exp_vec());
      end
      if (door && !prev_door) stops.push_back(int'(cur_floor));
      prev_door = door;
    end
    checks++;
    if (stops.size() != 3 || stops[0] != 4 || stops[1] != 6 || stops[2] != 0) begin
      errors++; $display("FAIL scan_order got %p exp '{4, 6, 0}", stops);
    end
  endtask

  task automatic test_door_reload();
    int n;
    do_reset();
    step(1, 1, 3);
    n = 0;
    while (!(m_mode == MDoor && m_due - cyc == 5) && n < 300) begin step(0, 1, 0); n++; end
    step(1, 1, 3);
    checks++;
    if ({pending[3], door} !== 2'b01) begin
      errors++; $display("FAIL reload_pend got pend3=%b door=%b exp 0 1", pending[3], door);
    end
    n = 1;
    while (door && n < 100) begin
      step(0, 1, 0);
      if (door) n++;
    end
    checks++;
    if (n != DC) begin errors++; $display("FAIL reload_door_cycles got %0d exp %0d", n, DC); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 1, 5);
    step(1, 1, 5);
    checks++;
    if (pending !== 8'h20) begin
      errors++; $display("FAIL dup_request got %h exp 20", pending);
    end
    step(0, 0, 0);
    checks++;
    if (pending !== 8'h20 || !busy) begin
      errors++; $display("FAIL auth_drop_keeps got %h busy%b exp 20 1", pending, busy);
    end
  endtask

  task automatic test_reset_mid_move();
    int n;
    do_reset();
    step(1, 1, 2);
    n = 0;
    while (m_floor != 1 && n < 100) begin step(0, 1, 0); n++; end
    repeat (5) step(0, 1, 0);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 16'h0) begin
      errors++; $display("FAIL async_reset got %h exp %h", dut_vec(), 16'h0);
    end
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_random();
    bit v, a;
    logic [2:0] f;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      v = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 7) != 0);
      f = 3'($urandom_range(0, 7));
      step(v, a, f);
      checks++;
      if (dut_vec() !== exp_vec() || $countones({mu, md, door}) > 1) begin
        errors++; $display("FAIL random_cycle%0d got %h exp %h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_single_trip();
    test_auth_reject();
    test_out_of_range();
    test_scan();
    test_door_reload();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Schedules car motion and door timing for the elevator from a bitmap of pending floor requests. Floor requests come from the authenticated keypad front end. Each request is a single-cycle valid pulse carrying a floor number, qualified by an auth level. The block serves requests in SCAN order (keep direction while requests remain ahead) and drives the motor-direction and door outputs plus the current-floor display.

Parameters:
NUM_FLOORS, 8, number of floors served (2..16)
FLOOR_W, 3, width of floor index (ceil log2 NUM_FLOORS)
MOVE_CYCLES, 16, CLK cycles to travel one floor (>=2)
DOOR_CYCLES, 32, CLK cycles door stays open (>=2)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
auth  input  1  high = keypad session logged in; requests ignored when low
req_valid  input  1  one-cycle request strobe
req_floor  input  FLOOR_W  requested floor, sampled when req_valid=1
req_err  output  1  one-cycle pulse: rejected request (floor>=NUM_FLOORS, or auth=0)
pending  output  NUM_FLOORS  outstanding request bitmap, bit i = floor i
current_floor  output  FLOOR_W  floor the car is at, or last floor passed
move_up  output  1  motor up
move_down  output  1  motor down
door_open  output  1  door open
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, pending=0, current_floor=0, dir_up=1, counters=0, all outputs 0.
- Request accept (every cycle, any state):
  - If req_valid && auth && req_floor<NUM_FLOORS, set pending[req_floor] next cycle.
  - If req_valid with auth=0 or floor out of range: pending is unchanged and req_err=1 next cycle.
  - Exception: if state=DOOR and req_floor==current_floor, the pending bit is not set. The door timer reloads to DOOR_CYCLES-1 instead.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE, evaluated each cycle on the registered pending value:
  - pending[current_floor]=1 -> DOOR; clear that bit; timer=DOOR_CYCLES-1.
  - Else with above = any pending bit > current_floor and below = any pending bit < current_floor:
    - (dir_up && above) or (!below && above) -> MOVE_UP, dir_up=1.
    - Otherwise, if below -> MOVE_DOWN, dir_up=0.
    - Otherwise stay IDLE.
- MOVE_UP/MOVE_DOWN:
  - On entry, move counter=MOVE_CYCLES-1; move_up or move_down is high for the whole state.
  - Counter decrements each cycle. At 0, current_floor increments or decrements, then:
    - pending[new floor]=1 -> DOOR; clear the bit; load the door timer.
    - Else a request remains further ahead in the same direction -> stay in the state and reload the counter.
    - Else -> IDLE, which may reverse direction.
  - Floor latency: exactly MOVE_CYCLES cycles per floor from entering the move state.
- DOOR:
  - door_open=1; the timer decrements.
  - At 0 -> IDLE. door_open is high for exactly DOOR_CYCLES cycles unless a same-floor reload extends it.
- Boundaries:
  - current_floor never exceeds NUM_FLOORS-1 and never goes below 0. MOVE_UP is never entered at the top floor; MOVE_DOWN is never entered at floor 0.
  - Simultaneous set and clear of the same bit (arrival cycle): the clear wins and the door reload rule applies.
  - A request for a floor already pending is idempotent.
  - move_up, move_down and door_open are mutually exclusive.
  - Deasserting auth does not cancel pending requests.
  - RST mid-move or mid-door returns the block to the reset values immediately.

Test Plan:
- Reset, then auth=1 and a request for floor 3 at t0 -> MOVE_UP. current_floor steps 1, 2, 3 at 16-cycle spacing; door_open is high for 32 cycles; then IDLE, pending=0.
- auth=0 and a request for floor 5 -> req_err pulses for 1 cycle, pending stays 0, busy=0.
- Request for floor 9 with NUM_FLOORS=8 (req_floor=3'b... drives all ones)? -> use NUM_FLOORS=6 with floor 7 -> req_err=1, no state change.
- Car at floor 2 moving up toward 6; a request for 4 arrives mid-move, then a request for 0 -> car stops at 4, then at 6, then reverses to 0 (SCAN order).
- Door open at floor 3 with 5 cycles left; request floor 3 -> door timer reloads to 31, pending[3] stays 0.
- RST asserted while the car is between floors 1 and 2 -> all outputs 0 asynchronously, current_floor=0, pending=0.
